tdm_demux: RTL

TDM_DEMUX -- requirements
Module: tdm_demux

---
 rtl/tdm_pkg.sv | 7 +
 rtl/tdm_slot.sv | 29 ++
 rtl/tdm_demux.sv | 84 ++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared defaults for the TDM demultiplexer slice.
package tdm_pkg;

  localparam int DEFAULT_W = 8;
  localparam int DEFAULT_N = 4;

endpackage

// File: rtl/tdm_slot.sv
// One-entry output buffer for a single demultiplexer channel.
module tdm_slot
  import tdm_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] load_data,
  output logic         valid,
  output logic [W-1:0] data
);

  // A load always wins over a drain, so a same-cycle drain+reload keeps the slot full with the new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: routes a framed input word stream round-robin onto N buffered channels.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int W = DEFAULT_W,
  parameter int N = DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic           in_sync,
  input  logic [W-1:0]   in_data,
  output logic           in_ready,
  output logic [N-1:0]   out_valid,
  input  logic [N-1:0]   out_ready,
  output logic [N*W-1:0] out_data,
  output logic           sync_err
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] target;
  logic [PW-1:0] ptr_next;
  logic          accept;
  logic [N-1:0]  load;
  logic [N-1:0]  drain;

  // A sync word always forces channel 0; otherwise the word goes where the pointer says.
  always_comb begin
    target = ptr;
    if (in_sync) begin
      target = '0;
    end
  end

  // Only the targeted slot can block the input; other full slots never stall the stream.
  assign in_ready = !out_valid[target] || out_ready[target];
  assign accept   = in_valid && in_ready;

  // Next channel after the one just written, wrapping from the last channel back to 0.
  always_comb begin
    ptr_next = target + 1'b1;
    if (target == PW'(N - 1)) begin
      ptr_next = '0;
    end
  end

  // The pointer only moves on an accepted word, so stalls and idle cycles leave the frame position intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= ptr_next;
    end
  end

  // Flag a sync word that arrives while the frame is not at channel 0; the word is still realigned to channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err <= 1'b0;
    end else begin
      sync_err <= accept && in_sync && (ptr != '0);
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_slot
    assign load[k]  = accept && (target == PW'(k));
    assign drain[k] = out_valid[k] && out_ready[k];

    tdm_slot #(
      .W(W)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[k]),
      .drain    (drain[k]),
      .load_data(in_data),
      .valid    (out_valid[k]),
      .data     (out_data[k*W +: W])
    );
  end

endmodule
